// File: rtl/bp_fe_pkg.sv
// rtl/bp_fe_pkg.sv - front-end fetch control command and state types
package bp_fe_pkg;

  typedef enum logic [1:0] {
    e_attaboy  = 2'd0,
    e_redirect = 2'd1,
    e_fence    = 2'd2,
    e_restart  = 2'd3
  } bp_fe_ctrl_cmd_e;

  // The fence state cannot reuse e_fence, which already names the fence command.
  typedef enum logic [1:0] {
    e_wait       = 2'd0,
    e_run        = 2'd1,
    e_miss       = 2'd2,
    e_fence_wait = 2'd3
  } bp_fe_fetch_state_e;

endpackage

// File: rtl/bsg_dff_reset.sv
// rtl/bsg_dff_reset.sv - register with synchronous active-high reset to zero
module bsg_dff_reset #(
  parameter int width_p = 1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] data_i,
  output logic [width_p-1:0] data_o
);

  // Clear on reset, otherwise follow the input every cycle.
  always_ff @(posedge clk_i) begin
    if (reset_i) data_o <= '0;
    else         data_o <= data_i;
  end

endmodule

// File: rtl/bsg_dff_reset_en.sv
// rtl/bsg_dff_reset_en.sv - enabled register with synchronous active-high reset to zero
module bsg_dff_reset_en #(
  parameter int width_p = 1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               en_i,
  input  logic [width_p-1:0] data_i,
  output logic [width_p-1:0] data_o
);

  // Clear on reset, otherwise load only when enabled.
  always_ff @(posedge clk_i) begin
    if (reset_i)   data_o <= '0;
    else if (en_i) data_o <= data_i;
  end

endmodule

// File: rtl/bp_fe_fetch_ctrl.sv
// rtl/bp_fe_fetch_ctrl.sv - front-end fetch controller: BE commands, miss replay, fences
module bp_fe_fetch_ctrl
  import bp_fe_pkg::*;
#(
  parameter int vaddr_width_p               = 39,
  parameter int branch_metadata_fwd_width_p = 36
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,

  input  logic                                   cmd_v_i,
  input  logic [1:0]                             cmd_type_i,
  input  logic [vaddr_width_p-1:0]               cmd_pc_i,
  input  logic                                   cmd_taken_i,
  input  logic                                   cmd_miss_i,
  input  logic                                   cmd_nonbr_i,
  input  logic [branch_metadata_fwd_width_p-1:0] cmd_br_metadata_i,
  output logic                                   cmd_yumi_o,

  output logic                                   resolve_v_o,
  output logic                                   resolve_miss_o,
  output logic                                   resolve_taken_o,
  output logic                                   resolve_nonbr_o,
  output logic [vaddr_width_p-1:0]               resolve_pc_o,
  output logic [branch_metadata_fwd_width_p-1:0] resolve_br_metadata_o,
  input  logic                                   resolve_yumi_i,

  output logic                                   next_pc_ready_o,
  input  logic                                   override_v_i,
  input  logic                                   fetch_v_i,
  input  logic [vaddr_width_p-1:0]               fetch_pc_i,

  input  logic                                   icache_ready_i,
  input  logic                                   icache_miss_i,
  input  logic                                   icache_fence_done_i,
  output logic                                   icache_fence_v_o,
  output logic                                   poison_o,

  input  logic                                   fe_queue_ready_i,
  output logic                                   fe_queue_v_o
);

  bp_fe_fetch_state_e       state_r, state_n;
  logic [1:0]               state_q;
  logic [vaddr_width_p-1:0] replay_pc_r, replay_pc_n;
  logic                     replay_pc_en;
  logic                     replay_detect;
  logic                     resolve_attaboy;
  logic                     poison_r;
  logic                     reset_r;
  logic                     quiet;
  bp_fe_ctrl_cmd_e          cmd_type;

  assign cmd_type = bp_fe_ctrl_cmd_e'(cmd_type_i);
  assign state_r  = bp_fe_fetch_state_e'(state_q);

  // Outputs stay silent while in reset and for the first cycle after it drops.
  assign quiet = reset_i | reset_r;

  bsg_dff_reset #(.width_p(2)) state_reg (
    .clk_i(clk_i), .reset_i(reset_i), .data_i(state_n), .data_o(state_q)
  );

  bsg_dff_reset_en #(.width_p(vaddr_width_p)) replay_pc_reg (
    .clk_i(clk_i), .reset_i(reset_i), .en_i(replay_pc_en),
    .data_i(replay_pc_n), .data_o(replay_pc_r)
  );

  bsg_dff_reset #(.width_p(1)) poison_reg (
    .clk_i(clk_i), .reset_i(reset_i), .data_i(poison_o), .data_o(poison_r)
  );

  // Remember that reset was high last cycle to mask the first post-reset cycle.
  always_ff @(posedge clk_i) begin
    reset_r <= reset_i;
  end

  // Command arbitration, replay/fence sequencing and next-state selection.
  always_comb begin
    state_n               = state_r;
    cmd_yumi_o            = 1'b0;
    resolve_v_o           = 1'b0;
    resolve_miss_o        = 1'b0;
    resolve_taken_o       = 1'b0;
    resolve_nonbr_o       = 1'b0;
    resolve_pc_o          = '0;
    resolve_br_metadata_o = '0;
    resolve_attaboy       = 1'b0;
    next_pc_ready_o       = 1'b0;
    icache_fence_v_o      = 1'b0;
    replay_detect         = 1'b0;
    replay_pc_en          = 1'b0;
    replay_pc_n           = fetch_pc_i;

    if (!quiet) begin
      if (state_r == e_fence_wait) begin
        if (icache_fence_done_i) state_n = e_miss;
      end else begin
        if (cmd_v_i) begin
          if (cmd_type == e_fence) begin
            cmd_yumi_o       = 1'b1;
            icache_fence_v_o = 1'b1;
            replay_pc_en     = 1'b1;
            replay_pc_n      = cmd_pc_i;
            state_n          = e_fence_wait;
          end else if (cmd_type == e_attaboy && state_r == e_wait) begin
            cmd_yumi_o = 1'b1;
          end else begin
            resolve_v_o           = 1'b1;
            resolve_pc_o          = cmd_pc_i;
            resolve_br_metadata_o = cmd_br_metadata_i;
            resolve_attaboy       = (cmd_type == e_attaboy);
            if (cmd_type == e_restart) begin
              resolve_miss_o = 1'b1;
            end else begin
              resolve_miss_o  = cmd_miss_i;
              resolve_taken_o = cmd_taken_i;
              resolve_nonbr_o = cmd_nonbr_i;
            end
            cmd_yumi_o = resolve_yumi_i;
            if (resolve_yumi_i && !resolve_attaboy) state_n = e_run;
          end
        end else if (state_r == e_miss && icache_ready_i && fe_queue_ready_i) begin
          resolve_v_o  = 1'b1;
          resolve_pc_o = replay_pc_r;
          if (resolve_yumi_i) state_n = e_run;
        end

        if (state_r == e_run) begin
          next_pc_ready_o = icache_ready_i & fe_queue_ready_i;
          // An accepted command wins over a same-cycle miss or full queue.
          if (fetch_v_i && (icache_miss_i || !fe_queue_ready_i) && !cmd_yumi_o) begin
            replay_detect = 1'b1;
            replay_pc_en  = 1'b1;
            replay_pc_n   = fetch_pc_i;
            state_n       = e_miss;
          end
        end
      end
    end
  end

  assign poison_o = ~quiet & ((resolve_v_o & resolve_yumi_i & ~resolve_attaboy)
                              | replay_detect | override_v_i);

  assign fe_queue_v_o = ~quiet & fetch_v_i & ~icache_miss_i & fe_queue_ready_i
                        & (state_r == e_run) & ~poison_r;

endmodule
